// File: rtl/core_mem_responder.sv
// OBI-style subordinate memory: req/gnt address phase with optional grant wait
// states, one-cycle rvalid response, byte-enable writes and out-of-range error.
module core_mem_responder #(
  parameter logic [31:0] BaseAddr      = 32'h1000_0000,
  parameter int unsigned NumWords      = 256,
  parameter int unsigned GntWaitCycles = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned IdxW    = $clog2(NumWords);
  localparam logic [32:0] EndAddr = {1'b0, BaseAddr} + 33'(4 * NumWords);
  localparam logic [3:0]  WaitCnt = 4'(GntWaitCycles);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            gnt;
  logic            hs;
  logic            hit;
  logic [IdxW-1:0] idx;
  logic [31:0]     mem_q [NumWords];
  logic            rvalid_q, rvalid_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;

  // BaseAddr is aligned to the memory size, so the word index is simply the
  // low address bits above the byte offset.
  assign hit = ({1'b0, addr_i} >= {1'b0, BaseAddr}) && ({1'b0, addr_i} < EndAddr);
  assign idx = addr_i[IdxW+1:2];

  // Handshake: a transfer happens in any cycle with req_i & gnt_o; the
  // initiator keeps attributes stable until then and always accepts rvalid_o.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    if (GntWaitCycles == 0) begin
      gnt = req_i;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_i) begin
            state_d = StWait;
            cnt_d   = 4'd1;
          end
        end
        StWait: begin
          if (!req_i) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
          end else if (cnt_q == WaitCnt) begin
            gnt     = 1'b1;
            state_d = StIdle;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  assign hs = req_i & gnt;

  always_comb begin
    rvalid_d = hs;
    err_d    = hs & ~hit;
    rdata_d  = 32'd0;
    if (hs && hit && !we_i) rdata_d = mem_q[idx];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is deliberately not reset; writes land at the grant edge so a
  // read granted in the next cycle already sees them.
  always_ff @(posedge clk_i) begin
    if (hs && hit && we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign gnt_o    = gnt;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign busy_o   = (state_q == StWait) | rvalid_q;

endmodule

// File: tb/tb_core_mem_responder.sv
// Bench for core_mem_responder: a zero-wait and a three-wait instance, table
// vectors, a memory reference model with random traffic, and reset corners.
module tb_core_mem_responder;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          NW   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req3;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt0, rvalid0, err0, busy0;
  logic [31:0] rdata0;
  logic        gnt3, rvalid3, err3, busy3;
  logic [31:0] rdata3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [NW];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  core_mem_responder #(.BaseAddr(BASE), .NumWords(NW), .GntWaitCycles(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .gnt_o(gnt0), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid0), .rdata_o(rdata0),
    .err_o(err0), .busy_o(busy0)
  );

  core_mem_responder #(.BaseAddr(BASE), .NumWords(NW), .GntWaitCycles(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req3), .gnt_o(gnt3), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid3), .rdata_o(rdata3),
    .err_o(err3), .busy_o(busy3)
  );

  typedef struct {
    string       name;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_gnt;
    logic        exp_rv;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: inputs driven just after a rising edge, gnt sampled mid-cycle,
  // response outputs sampled just after the following rising edge.
  task automatic step(input bit sel, input logic rq, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d,
                      output logic g, output logic rv, output logic er,
                      output logic [31:0] rd, output logic bz);
    if (sel) req3 = rq; else req0 = rq;
    we = w; addr = a; be = b; wdata = d;
    #2;
    g = sel ? gnt3 : gnt0;
    @(posedge clk);
    #1;
    rv = sel ? rvalid3 : rvalid0;
    er = sel ? err3 : err0;
    rd = sel ? rdata3 : rdata0;
    bz = sel ? busy3 : busy0;
    req0 = 1'b0;
    req3 = 1'b0;
  endtask

  task automatic model_op(input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d);
    longint      off;
    bit          hit;
    int          idx;
    logic [31:0] exp_rd;
    logic        g, rv, er, bz;
    logic [31:0] rd;
    off    = longint'(a) - longint'(BASE);
    hit    = (off >= 0) && (off < 4 * NW);
    idx    = hit ? int'(off / 4) : 0;
    exp_rd = 32'd0;
    if (hit && !w) exp_rd = model_mem[idx];
    if (hit && w) begin
      for (int k = 0; k < 4; k++) if (b[k]) model_mem[idx][8*k +: 8] = d[8*k +: 8];
    end
    exp_q.push_back(exp_rd);
    step(1'b0, 1'b1, w, a, b, d, g, rv, er, rd, bz);
    chk("op_gnt", g, 1);
    chk("op_rvalid", rv, 1);
    chk("op_err", er, !hit);
    chk("op_rdata", rd, exp_q.pop_front());
  endtask

  task automatic idle_step(input bit sel, input string name);
    logic        g, rv, er, bz;
    logic [31:0] rd;
    step(sel, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, g, rv, er, rd, bz);
    chk({name, "_gnt"}, g, 0);
    chk({name, "_rvalid"}, rv, 0);
    chk({name, "_rdata"}, rd, 0);
  endtask

  initial begin
    logic        g, rv, er, bz;
    logic [31:0] rd;

    vecs[0]  = '{"t1_wr",      1, 1, BASE + 32'd8,  4'hF, 32'hDEADBEEF, 1, 1, 0, 32'h0};
    vecs[1]  = '{"t1_rd",      1, 0, BASE + 32'd8,  4'hF, 32'h0,        1, 1, 0, 32'hDEADBEEF};
    vecs[2]  = '{"idle",       0, 0, BASE,          4'h0, 32'h0,        0, 0, 0, 32'h0};
    vecs[3]  = '{"t2_init",    1, 1, BASE + 32'd16, 4'hF, 32'h11223344, 1, 1, 0, 32'h0};
    vecs[4]  = '{"t2_wr",      1, 1, BASE + 32'd16, 4'h5, 32'hAABBCCDD, 1, 1, 0, 32'h0};
    vecs[5]  = '{"t2_rd",      1, 0, BASE + 32'd16, 4'h0, 32'h0,        1, 1, 0, 32'h11BB33DD};
    vecs[6]  = '{"be0_wr",     1, 1, BASE + 32'd8,  4'h0, 32'hFFFFFFFF, 1, 1, 0, 32'h0};
    vecs[7]  = '{"be0_rd",     1, 0, BASE + 32'd8,  4'hF, 32'h0,        1, 1, 0, 32'hDEADBEEF};
    vecs[8]  = '{"t3_w15",     1, 1, BASE + 32'd60, 4'hF, 32'h5A5A0F0F, 1, 1, 0, 32'h0};
    vecs[9]  = '{"t3_rd_oor",  1, 0, BASE + 32'd64, 4'hF, 32'h0,        1, 1, 1, 32'h0};
    vecs[10] = '{"t3_wr_oor",  1, 1, BASE - 32'd4,  4'hF, 32'h12345678, 1, 1, 1, 32'h0};
    vecs[11] = '{"t3_rd15",    1, 0, BASE + 32'd60, 4'hF, 32'h0,        1, 1, 0, 32'h5A5A0F0F};
    vecs[12] = '{"lowbits_rd", 1, 0, BASE + 32'h13, 4'hF, 32'h0,        1, 1, 0, 32'h11BB33DD};

    rst_n = 1'b0; req0 = 1'b0; req3 = 1'b0;
    addr = 32'd0; we = 1'b0; be = 4'd0; wdata = 32'd0;
    #1;
    chk("rst_gnt0", gnt0, 0);     chk("rst_gnt3", gnt3, 0);
    chk("rst_rvalid0", rvalid0, 0); chk("rst_rvalid3", rvalid3, 0);
    chk("rst_rdata0", rdata0, 0); chk("rst_err0", err0, 0);
    chk("rst_busy0", busy0, 0);   chk("rst_busy3", busy3, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(1'b0, vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
           g, rv, er, rd, bz);
      chk({vecs[i].name, "_gnt"}, g, vecs[i].exp_gnt);
      chk({vecs[i].name, "_rvalid"}, rv, vecs[i].exp_rv);
      chk({vecs[i].name, "_err"}, er, vecs[i].exp_err);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
    end

    // Model takes over: give every word a known value first.
    for (int i = 0; i < NW; i++) model_op(1'b1, BASE + 32'(4 * i), 4'hF, $urandom);

    // Back-to-back: 8 writes, 8 reads, then write and read the same word.
    for (int i = 0; i < 8; i++) model_op(1'b1, BASE + 32'(4 * i), 4'hF, $urandom);
    for (int i = 0; i < 8; i++) model_op(1'b0, BASE + 32'(4 * i), 4'h0, 32'd0);
    model_op(1'b1, BASE + 32'd20, 4'hF, 32'hC0FFEE01);
    model_op(1'b0, BASE + 32'd20, 4'h0, 32'd0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) idle_step(1'b0, "rnd_idle");
      else model_op(1'($urandom_range(0, 1)),
                    BASE - 32'd16 + 32'($urandom_range(0, 4 * NW + 28)),
                    4'($urandom_range(0, 15)), $urandom);
    end

    // Three wait states: write then read word 1, grant on the fourth req cycle.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, BASE + 32'd4, 4'hF, 32'hCAFE0001, g, rv, er, rd, bz);
      chk("t4_wr_gnt", g, (i == 3));
      chk("t4_wr_rvalid", rv, (i == 3));
      chk("t4_wr_busy", bz, 1);
    end
    chk("t4_wr_err", er, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, BASE + 32'd4, 4'h0, 32'd0, g, rv, er, rd, bz);
      chk("t4_rd_gnt", g, (i == 3));
      chk("t4_rd_rvalid", rv, (i == 3));
    end
    chk("t4_rd_rdata", rd, 32'hCAFE0001);
    chk("t4_rd_err", er, 0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, BASE + 32'd4, 4'h0, 32'd0, g, rv, er, rd, bz);
      chk("t4_drop_gnt", g, 0);
      chk("t4_drop_busy_wait", bz, 1);
    end
    step(1'b1, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0, g, rv, er, rd, bz);
    chk("t4_drop_gnt_low", g, 0);
    chk("t4_drop_busy_fall", bz, 0);
    chk("t4_drop_rvalid", rv, 0);
    for (int i = 0; i < 3; i++) idle_step(1'b1, "t4_after_drop");

    // Reset while a read response is on the bus.
    model_op(1'b0, BASE + 32'd20, 4'h0, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_rvalid_async", rvalid0, 0);
    chk("t6_rdata_async", rdata0, 0);
    chk("t6_busy_async", busy0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle_step(1'b0, "t6_after_rst");
    model_op(1'b0, BASE + 32'd20, 4'h0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
